cva6_rvfi_trace_serializer: RTL and testbench

Commit-port serializer and arbiter for the RVFI trace path. Each cycle it accepts up to NrCommitPorts retired-instruction trace records and buffers them in retirement order, lowest port index first. It then drains them one per cycle over a single valid/ready stream, which feeds a single-port trace sink (for example a trace encoder or DPI logger). Overflow is handled by an all-or-nothing drop policy: entries are discarded, counted and flagged, and no partial bundle is ever stored.

---
 rtl/cva6_rvfi_trace_serializer.sv | 199 +++++++++++++++++++
 tb/tb_cva6_rvfi_trace_serializer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cva6_rvfi_trace_serializer.sv
// Purpose : serialize up to NrCommitPorts RVFI retirement records per cycle into one in-order stream.
// Latency : first-word fall-through, so a record pushed at edge t is at the head right after edge t.
// Backpressure: trace_ready_i stalls the head; a bundle that does not fit is dropped whole and counted.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   rvfi_valid_i/entry_i    per-port retirement records, port p at [p*EntryW +: EntryW]
//   clear_i                 synchronous flush of buffer, sequence, drop counter and overflow flag
//   trace_valid_o/ready_i   head-of-buffer valid/ready handshake
//   trace_entry_o/seq_o     head record and its sequence tag
//   count_o                 occupancy (0..Depth)
//   overflow_o, drop_cnt_o  sticky drop flag and saturating dropped-record count
module cva6_rvfi_trace_serializer #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned EntryW        = 512,
  parameter int unsigned Depth         = 8,   // power of two, >= 2 and >= NrCommitPorts
  parameter int unsigned SeqW          = 32,
  parameter int unsigned DropCntW      = 16   // >= 3
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrCommitPorts-1:0]        rvfi_valid_i,
  input  logic [NrCommitPorts*EntryW-1:0] rvfi_entry_i,
  input  logic                            clear_i,
  output logic                            trace_valid_o,
  output logic [EntryW-1:0]               trace_entry_o,
  output logic [SeqW-1:0]                 trace_seq_o,
  input  logic                            trace_ready_i,
  output logic [$clog2(Depth):0]          count_o,
  output logic                            overflow_o,
  output logic [DropCntW-1:0]             drop_cnt_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned NW = $clog2(NrCommitPorts + 1);

  // Registered state
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [SeqW-1:0]     seq_q, seq_d;
  logic [DropCntW-1:0] drop_cnt_q, drop_cnt_d;
  logic                overflow_q, overflow_d;

  logic [EntryW-1:0]   mem_q     [Depth];
  logic [SeqW-1:0]     seq_mem_q [Depth];

  // Per-slot write port produced by the compaction network
  logic                wr_en  [Depth];
  logic [EntryW-1:0]   wr_dat [Depth];
  logic [SeqW-1:0]     wr_seq [Depth];

  // Bundle evaluation
  logic [NW-1:0]       rank [NrCommitPorts];
  logic [NW-1:0]       n_valid;
  logic [CW-1:0]       n_ext;
  logic [CW-1:0]       free;
  logic                do_push;
  logic                do_drop;
  logic                pop;
  logic [DropCntW:0]   drop_sum;
  logic [AW-1:0]       slot;

  // rank[p] = number of valid ports below p; this is both the slot offset
  // from wr_ptr and the sequence offset, which squeezes out invalid ports.
  always_comb begin
    n_valid = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      rank[p] = n_valid;
      if (rvfi_valid_i[p]) begin
        n_valid = n_valid + NW'(1);
      end
    end
  end

  // Acceptance looks at count_q only: a same-cycle pop does not make room,
  // which keeps the accept/drop decision off the trace_ready_i path.
  always_comb begin
    n_ext   = CW'(n_valid);
    free    = CW'(Depth) - count_q;
    pop     = trace_valid_o && trace_ready_i;
    do_push = !clear_i && (n_valid != '0) && (n_ext <= free);
    do_drop = !clear_i && (n_ext > free);
  end

  // Scatter valid records into consecutive slots starting at wr_ptr_q.
  always_comb begin
    slot = '0;
    for (int i = 0; i < Depth; i++) begin
      wr_en[i]  = 1'b0;
      wr_dat[i] = '0;
      wr_seq[i] = '0;
    end
    if (do_push) begin
      for (int p = 0; p < NrCommitPorts; p++) begin
        if (rvfi_valid_i[p]) begin
          slot         = wr_ptr_q + AW'(rank[p]);
          wr_en[slot]  = 1'b1;
          wr_dat[slot] = rvfi_entry_i[p*EntryW +: EntryW];
          wr_seq[slot] = seq_q + SeqW'(rank[p]);
        end
      end
    end
  end

  // Next-state logic; clear_i overrides push, pop and drop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    drop_sum   = {1'b0, drop_cnt_q} + (DropCntW+1)'(n_valid);

    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      seq_d      = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(n_valid);
        seq_d    = seq_q + SeqW'(n_valid);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // A dropped bundle leaves seq_q untouched so the output tags stay dense.
      if (do_drop) begin
        drop_cnt_d = drop_sum[DropCntW] ? '1 : drop_sum[DropCntW-1:0];
        overflow_d = 1'b1;
      end
      count_d = count_q + (do_push ? n_ext : CW'(0)) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage. Pushes only target free slots, so the head slot is never
  // overwritten while it is valid and the output holds under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i]     <= '0;
        seq_mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (wr_en[i]) begin
          mem_q[i]     <= wr_dat[i];
          seq_mem_q[i] <= wr_seq[i];
        end
      end
    end
  end

  assign trace_valid_o = (count_q != '0);
  assign trace_entry_o = mem_q[rd_ptr_q];
  assign trace_seq_o   = seq_mem_q[rd_ptr_q];
  assign count_o       = count_q;
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_cnt_q;

  // Protocol and sanity properties
  a_count_le_depth : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CW'(Depth));

  a_inputs_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({rvfi_valid_i, clear_i}));

  // trace_ready_i may float while nothing is offered.
  a_ready_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
    trace_valid_o |-> !$isunknown(trace_ready_i));

  a_head_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (trace_valid_o && !trace_ready_i && !clear_i) |=>
      ($stable(trace_entry_o) && $stable(trace_seq_o)));

endmodule

// File: tb/tb_cva6_rvfi_trace_serializer.sv
module tb_cva6_rvfi_trace_serializer;

  localparam int NP    = 2;
  localparam int EW    = 64;
  localparam int DEPTH = 8;
  localparam int SW    = 32;
  localparam int DW    = 4;
  localparam int DMAX  = (1 << DW) - 1;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NP-1:0]     rvfi_valid_i;
  logic [NP*EW-1:0]  rvfi_entry_i;
  logic              clear_i;
  logic              trace_valid_o;
  logic [EW-1:0]     trace_entry_o;
  logic [SW-1:0]     trace_seq_o;
  logic              trace_ready_i;
  logic [3:0]        count_o;
  logic              overflow_o;
  logic [DW-1:0]     drop_cnt_o;

  always #5 clk_i = ~clk_i;

  cva6_rvfi_trace_serializer #(
    .NrCommitPorts(NP),
    .EntryW       (EW),
    .Depth        (DEPTH),
    .SeqW         (SW),
    .DropCntW     (DW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rvfi_valid_i (rvfi_valid_i),
    .rvfi_entry_i (rvfi_entry_i),
    .clear_i      (clear_i),
    .trace_valid_o(trace_valid_o),
    .trace_entry_o(trace_entry_o),
    .trace_seq_o  (trace_seq_o),
    .trace_ready_i(trace_ready_i),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  typedef struct {
    logic [EW-1:0] e;
    logic [SW-1:0] s;
  } rec_t;

  rec_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          m_cnt;
  logic [SW-1:0] m_seq;
  int          m_drop;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt  = 0;
    m_seq  = '0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic drive(input logic [NP-1:0] v, input logic rdy, input logic clr);
    rvfi_valid_i = v;
    for (int p = 0; p < NP; p++) rvfi_entry_i[p*EW +: EW] = {$urandom, $urandom};
    trace_ready_i = rdy;
    clear_i       = clr;
  endtask

  // Check registered outputs at the falling edge, advance the reference
  // model with the inputs held for this cycle, then move past the rising edge.
  task automatic step(input string tag);
    rec_t r;
    int   n;
    int   free;
    @(negedge clk_i);
    chk({tag, ":valid"}, 64'(trace_valid_o), 64'(m_cnt != 0));
    chk({tag, ":count"}, 64'(count_o), 64'(m_cnt));
    chk({tag, ":ovf"},   64'(overflow_o), 64'(m_ovf));
    chk({tag, ":drop"},  64'(drop_cnt_o), 64'(m_drop));
    if (m_cnt != 0) begin
      chk({tag, ":entry"}, trace_entry_o, sb[0].e);
      chk({tag, ":seq"},   64'(trace_seq_o), 64'(sb[0].s));
    end
    if (clear_i) begin
      model_reset();
    end else begin
      n    = $countones(rvfi_valid_i);
      free = DEPTH - m_cnt;
      if (m_cnt != 0 && trace_ready_i) begin
        void'(sb.pop_front());
        m_cnt--;
      end
      if (n > 0 && n <= free) begin
        for (int p = 0; p < NP; p++) begin
          if (rvfi_valid_i[p]) begin
            r.e = rvfi_entry_i[p*EW +: EW];
            r.s = m_seq;
            m_seq = m_seq + 1;
            sb.push_back(r);
            m_cnt++;
          end
        end
      end else if (n > free) begin
        m_drop = (m_drop + n > DMAX) ? DMAX : m_drop + n;
        m_ovf  = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    drive('0, 1'b1, 1'b0);
    while (m_cnt != 0 && guard < 20) begin
      step(tag);
      guard++;
    end
    chk({tag, ":drained"}, 64'(count_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    drive('0, 1'b1, 1'b0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst:valid", 64'(trace_valid_o), 64'd0);
    chk("rst:count", 64'(count_o), 64'd0);
    chk("rst:ovf",   64'(overflow_o), 64'd0);
    chk("rst:drop",  64'(drop_cnt_o), 64'd0);
    rst_ni = 1'b1;

    // Single record on port 0, sink ready
    drive(2'b01, 1'b1, 1'b0);
    rvfi_entry_i[0 +: EW] = 64'hAAAA_0000_0000_0001;
    step("single");
    chk("single:head_valid", 64'(trace_valid_o), 64'd1);
    chk("single:head_entry", trace_entry_o, 64'hAAAA_0000_0000_0001);
    chk("single:head_seq",   64'(trace_seq_o), 64'd0);
    drive('0, 1'b1, 1'b0);
    step("single_pop");
    chk("single:empty", 64'(count_o), 64'd0);

    // Fill with both ports while stalled; fifth bundle is dropped
    drive('0, 1'b1, 1'b1);
    step("clr1");
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b0, 1'b0);
      step("fill");
    end
    chk("fill:count8", 64'(count_o), 64'd8);
    drive(2'b11, 1'b0, 1'b0);
    step("fill_drop");
    chk("fill:drop2", 64'(drop_cnt_o), 64'd2);
    chk("fill:ovf",   64'(overflow_o), 64'd1);
    chk("fill:still8", 64'(count_o), 64'd8);

    // Pop to 7, then a 2-record bundle does not fit even with a pop
    drive('0, 1'b1, 1'b0);
    step("to7");
    chk("to7:count", 64'(count_o), 64'd7);
    drive(2'b11, 1'b1, 1'b0);
    step("drop_at7");
    chk("drop_at7:count6", 64'(count_o), 64'd6);
    chk("drop_at7:drop4",  64'(drop_cnt_o), 64'd4);
    drive(2'b01, 1'b0, 1'b0);
    step("after_drop");
    drain("drain1");

    // Compaction: port 1 alone, then both ports
    drive('0, 1'b1, 1'b1);
    step("clr2");
    drive(2'b10, 1'b0, 1'b0);
    rvfi_entry_i[EW +: EW] = 64'hBBBB_0000_0000_000B;
    step("push_b");
    drive(2'b11, 1'b0, 1'b0);
    rvfi_entry_i[0 +: EW]  = 64'hCCCC_0000_0000_000C;
    rvfi_entry_i[EW +: EW] = 64'hDDDD_0000_0000_000D;
    step("push_cd");
    chk("compact:count3", 64'(count_o), 64'd3);
    chk("compact:head_b", trace_entry_o, 64'hBBBB_0000_0000_000B);
    chk("compact:seq0",   64'(trace_seq_o), 64'd0);
    drain("drain2");

    // Random traffic with random backpressure, pointers wrap many times
    drive('0, 1'b1, 1'b1);
    step("clr3");
    for (int i = 0; i < 40; i++) begin
      drive(NP'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      step("rand");
    end
    drain("drain3");

    // Drop counter saturation, then clear with a bundle present
    drive('0, 1'b1, 1'b1);
    step("clr4");
    for (int i = 0; i < 14; i++) begin
      drive(2'b11, 1'b0, 1'b0);
      step("sat");
    end
    chk("sat:drop15", 64'(drop_cnt_o), 64'd15);
    drive(2'b11, 1'b0, 1'b1);
    step("clr_with_push");
    chk("clr:count0", 64'(count_o), 64'd0);
    chk("clr:drop0",  64'(drop_cnt_o), 64'd0);
    chk("clr:ovf0",   64'(overflow_o), 64'd0);
    drive(2'b11, 1'b0, 1'b0);
    step("restart");
    chk("restart:seq0", 64'(trace_seq_o), 64'd0);
    drive(2'b11, 1'b0, 1'b0);
    step("load5a");
    drive(2'b01, 1'b0, 1'b0);
    step("load5b");
    chk("load5:count5", 64'(count_o), 64'd5);

    // Asynchronous reset mid-operation empties the buffer immediately
    drive('0, 1'b0, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("arst:valid", 64'(trace_valid_o), 64'd0);
    chk("arst:count", 64'(count_o), 64'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive('0, 1'b1, 1'b0);
    step("post_rst");
    step("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
